// File: rtl/imm_gen_stage.sv
// imm_gen_stage: pipelined XLEN immediate generator with 2-entry skid buffer, flush and stall counter
module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [2:0]       in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_sel,
  output logic             out_illegal,
  output logic [CNT_W-1:0] stall_cnt
);
  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;
  typedef struct packed {
    logic            ill;
    logic [2:0]      sel;
    logic [XLEN-1:0] imm;
  } entry_t;
  state_e state_q, state_d;
  entry_t new_e, m_q, m_d, k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] imm32;
  logic accept, pop, unused_opcode;
  assign unused_opcode = ^in_inst[6:0];
  assign imm32 = (in_sel == 3'd0) ? {in_inst[31:12], 12'b0} :
                 (in_sel == 3'd1) ? {{20{in_inst[31]}}, in_inst[31:20]} :
                 (in_sel == 3'd2) ? {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]} :
                 (in_sel == 3'd3) ? {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0} :
                 (in_sel == 3'd4) ? {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0} :
                 (in_sel == 3'd5) ? {27'b0, in_inst[19:15]} : 32'b0;
  // Every 32-bit form is already correctly extended, so RV64 just replicates bit 31
  always_comb begin
    new_e.imm = {XLEN{imm32[31]}};
    new_e.imm[31:0] = imm32;
    new_e.sel = in_sel;
    new_e.ill = &in_sel[2:1];
  end
  assign in_ready    = state_q != FULL;
  assign out_valid   = state_q != EMPTY;
  assign accept      = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign out_imm     = m_q.imm;
  assign out_sel     = m_q.sel;
  assign out_illegal = m_q.ill;
  assign stall_cnt   = cnt_q;
  assign cnt_d = (out_valid && !out_ready && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  always_comb begin
    state_d = state_q;
    m_d = m_q;
    k_d = k_q;
    if (flush) state_d = EMPTY;
    else
      case (state_q)
        EMPTY: if (accept) begin
          state_d = ONE;
          m_d = new_e;
        end
        ONE: if (accept && pop) m_d = new_e;
          else if (accept) begin
            state_d = FULL;
            k_d = new_e;
          end
          else if (pop) state_d = EMPTY;
        FULL: if (pop) begin
          state_d = ONE;
          m_d = k_q;
        end
        default: state_d = EMPTY;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= EMPTY;
      m_q <= '0;
      k_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      m_q <= m_d;
      k_q <= k_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: directed checks of RV32 and RV64 instances driven in lockstep
module tb_imm_gen_stage;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_inst = '0;
  logic [2:0] in_sel = '0;
  logic ov32, ir32, ill32, ov64, ir64, ill64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0] sel32, sel64;
  logic [15:0] sc32;
  logic [2:0] sc64;
  int n_cmp = 0, n_bad = 0;

  imm_gen_stage #(.XLEN(32), .CNT_W(16)) d32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir32),
    .in_inst(in_inst), .in_sel(in_sel), .out_valid(ov32), .out_ready(out_ready),
    .out_imm(imm32), .out_sel(sel32), .out_illegal(ill32), .stall_cnt(sc32));
  imm_gen_stage #(.XLEN(64), .CNT_W(3)) d64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir64),
    .in_inst(in_inst), .in_sel(in_sel), .out_valid(ov64), .out_ready(out_ready),
    .out_imm(imm64), .out_sel(sel64), .out_illegal(ill64), .stall_cnt(sc64));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [31:0] vi [10] = '{32'hFFF00093, 32'h800002B7, 32'h8000006F, 32'h000F9073, 32'hFE112E23,
                           32'hFE000EE3, 32'h00500093, 32'h12345037, 32'hFFFFFFFF, 32'h0080006F};
  logic [2:0]  vs [10] = '{3'd1, 3'd0, 3'd4, 3'd5, 3'd2, 3'd3, 3'd1, 3'd0, 3'd5, 3'd4};
  logic [63:0] ve [10] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000, 64'hFFFFFFFFFFF00000,
                           64'h000000000000001F, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC,
                           64'h0000000000000005, 64'h0000000012345000, 64'h000000000000001F,
                           64'h0000000000000008};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
    tick();
    n_cmp++;
    if ({ov32, ir32, imm32, sel32, ill32, sc32} !== {1'b0, 1'b1, 32'h0, 3'h0, 1'b0, 16'h0}) begin
      n_bad++;
      $display("FAIL reset32: got v=%b r=%b imm=%h sel=%0d ill=%b sc=%0d want 0 1 0 0 0 0",
               ov32, ir32, imm32, sel32, ill32, sc32);
    end
    n_cmp++;
    if ({ov64, ir64, imm64, sel64, ill64, sc64} !== {1'b0, 1'b1, 64'h0, 3'h0, 1'b0, 3'h0}) begin
      n_bad++;
      $display("FAIL reset64: got v=%b r=%b imm=%h sel=%0d ill=%b sc=%0d want 0 1 0 0 0 0",
               ov64, ir64, imm64, sel64, ill64, sc64);
    end
  endtask

  task automatic test_imm;
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1;
      in_inst = vi[i];
      in_sel = vs[i];
      tick();
      in_valid = 0;
      n_cmp++;
      if ({ov32, imm32, sel32, ill32} !== {1'b1, ve[i][31:0], vs[i], 1'b0}) begin
        n_bad++;
        $display("FAIL imm32[%0d]: got v=%b imm=%h sel=%0d ill=%b want 1 %h %0d 0",
                 i, ov32, imm32, sel32, ill32, ve[i][31:0], vs[i]);
      end
      n_cmp++;
      if ({ov64, imm64, sel64, ill64} !== {1'b1, ve[i], vs[i], 1'b0}) begin
        n_bad++;
        $display("FAIL imm64[%0d]: got v=%b imm=%h sel=%0d ill=%b want 1 %h %0d 0",
                 i, ov64, imm64, sel64, ill64, ve[i], vs[i]);
      end
      tick();
      n_cmp++;
      if (ov64 !== 1'b0 || ov32 !== 1'b0) begin
        n_bad++;
        $display("FAIL imm_pop[%0d]: got valid %b/%b want 0", i, ov32, ov64);
      end
    end
  endtask

  task automatic test_illegal;
    out_ready = 1;
    for (int s = 6; s < 8; s++) begin
      in_valid = 1;
      in_inst = (s == 6) ? 32'hFFFFFFFF : 32'h12345678;
      in_sel = 3'(s);
      tick();
      in_valid = 0;
      n_cmp++;
      if ({ov64, imm64, sel64, ill64, ov32, imm32, ill32} !== {1'b1, 64'h0, 3'(s), 1'b1, 1'b1, 32'h0, 1'b1}) begin
        n_bad++;
        $display("FAIL illegal[%0d]: got v=%b imm=%h sel=%0d ill=%b imm32=%h ill32=%b want 1 0 %0d 1 0 1",
                 s, ov64, imm64, sel64, ill64, imm32, ill32, s);
      end
      tick();
      n_cmp++;
      if (ov64 !== 1'b0) begin
        n_bad++;
        $display("FAIL illegal_pop[%0d]: got valid %b want 0", s, ov64);
      end
    end
  endtask

  task automatic test_backpressure;
    int sent = 0, recv = 0, cyc = 0, last_pop = -1;
    in_sel = 1;
    while (recv < 8 && cyc < 40) begin
      in_valid = sent < 8;
      in_inst = {12'(sent + 1), 20'h00093};
      out_ready = !(cyc >= 1 && cyc <= 3);
      if (cyc == 2) begin
        n_cmp++;
        if (ir64 !== 1'b0 || ir32 !== 1'b0) begin
          n_bad++;
          $display("FAIL bp_ready_drop: got in_ready %b/%b want 0", ir32, ir64);
        end
      end
      if (ov64 && out_ready) begin
        n_cmp++;
        if (imm64 !== 64'(recv + 1) || imm32 !== 32'(recv + 1)) begin
          n_bad++;
          $display("FAIL bp_order[%0d]: got %h/%h want %0d", recv, imm32, imm64, recv + 1);
        end
        recv++;
        last_pop = cyc;
      end
      if (in_valid && ir64) sent++;
      tick();
      cyc++;
    end
    in_valid = 0;
    n_cmp++;
    if (recv != 8 || last_pop != 11) begin
      n_bad++;
      $display("FAIL bp_throughput: got %0d entries last at cycle %0d want 8 at cycle 11", recv, last_pop);
    end
    n_cmp++;
    if (sc32 !== 16'd3 || sc64 !== 3'd3) begin
      n_bad++;
      $display("FAIL bp_stall: got %0d/%0d want 3", sc32, sc64);
    end
  endtask

  task automatic test_flush;
    in_sel = 1;
    out_ready = 0;
    in_valid = 1;
    in_inst = {12'h111, 20'h00093};
    tick();
    in_inst = {12'h222, 20'h00093};
    tick();
    n_cmp++;
    if (ir64 !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_full: got in_ready %b want 0", ir64);
    end
    flush = 1;
    in_inst = {12'h333, 20'h00093};
    out_ready = 1;
    tick();
    flush = 0;
    in_valid = 0;
    out_ready = 0;
    n_cmp++;
    if ({ov64, ir64, imm64, sc64, ov32, ir32, sc32} !== {1'b0, 1'b1, 64'h111, 3'd4, 1'b0, 1'b1, 16'd4}) begin
      n_bad++;
      $display("FAIL flush_state: got v=%b r=%b imm=%h sc=%0d v32=%b r32=%b sc32=%0d want 0 1 111 4 0 1 4",
               ov64, ir64, imm64, sc64, ov32, ir32, sc32);
    end
    tick();
    n_cmp++;
    if (ov64 !== 1'b0 || ov32 !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_drop: got valid %b/%b want 0", ov32, ov64);
    end
    out_ready = 1;
    in_valid = 1;
    in_inst = {12'h444, 20'h00093};
    tick();
    in_valid = 0;
    n_cmp++;
    if (ov64 !== 1'b1 || imm64 !== 64'h444 || imm32 !== 32'h444) begin
      n_bad++;
      $display("FAIL flush_next: got v=%b imm=%h/%h want 1 444", ov64, imm32, imm64);
    end
    tick();
  endtask

  task automatic test_saturate;
    in_sel = 1;
    out_ready = 0;
    in_valid = 1;
    in_inst = {12'h555, 20'h00093};
    tick();
    in_valid = 0;
    repeat (10) tick();
    n_cmp++;
    if (sc32 !== 16'd14 || sc64 !== 3'd7) begin
      n_bad++;
      $display("FAIL sat_stall: got %0d/%0d want 14/7", sc32, sc64);
    end
    n_cmp++;
    if (ov64 !== 1'b1 || imm64 !== 64'h555 || sel64 !== 3'd1) begin
      n_bad++;
      $display("FAIL sat_stable: got v=%b imm=%h sel=%0d want 1 555 1", ov64, imm64, sel64);
    end
    out_ready = 1;
    tick();
    n_cmp++;
    if (ov64 !== 1'b0 || sc64 !== 3'd7 || sc32 !== 16'd14) begin
      n_bad++;
      $display("FAIL sat_pop: got v=%b sc=%0d/%0d want 0 14/7", ov64, sc32, sc64);
    end
  endtask

  task automatic test_reset_mid;
    in_sel = 1;
    out_ready = 0;
    in_valid = 1;
    in_inst = {12'h666, 20'h00093};
    tick();
    in_inst = {12'h777, 20'h00093};
    tick();
    in_valid = 0;
    #2;
    rst_n = 0;
    #1;
    n_cmp++;
    if ({ov64, ir64, imm64, sc64, ov32, ir32, sc32} !== {1'b0, 1'b1, 64'h0, 3'd0, 1'b0, 1'b1, 16'd0}) begin
      n_bad++;
      $display("FAIL rst_async: got v=%b r=%b imm=%h sc=%0d v32=%b r32=%b sc32=%0d want 0 1 0 0 0 1 0",
               ov64, ir64, imm64, sc64, ov32, ir32, sc32);
    end
    #1;
    rst_n = 1;
    tick();
    out_ready = 1;
    in_valid = 1;
    in_inst = {12'h7FF, 20'h00093};
    tick();
    in_valid = 0;
    n_cmp++;
    if (ov64 !== 1'b1 || imm64 !== 64'h7FF || imm32 !== 32'h7FF) begin
      n_bad++;
      $display("FAIL rst_first: got v=%b imm=%h/%h want 1 7ff", ov64, imm32, imm64);
    end
    tick();
    n_cmp++;
    if (ov64 !== 1'b0 || ov32 !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_pop: got valid %b/%b want 0", ov32, ov64);
    end
  endtask

  initial begin
    test_reset();
    test_imm();
    test_illegal();
    test_backpressure();
    test_flush();
    test_saturate();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
